param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per entry (1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (2..256; need not be a power of 2).
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-1, level at or above which afull asserts.
REQ-004 SHALL have parameter AEMPTY_LVL, default 1, level at or below which aempty asserts.
REQ-005 SHALL have port clk  input  1  clock, all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port push  input  1  write request.
REQ-008 SHALL have port din  input  WIDTH  write data.
REQ-009 SHALL have port pop  input  1  read request.
REQ-010 SHALL have port dout  output  WIDTH  head-of-queue data (show-ahead).
REQ-011 SHALL have port full / empty  output  1 each  occupancy == DEPTH / == 0.
REQ-012 SHALL have port afull / aempty  output  1 each  level >= AFULL_LVL / level <= AEMPTY_LVL.
REQ-013 SHALL have port level  output  CW = clog2(DEPTH+1)  current occupancy.
REQ-014 SHALL have port max_level  output  CW  high-water mark of level since reset.
REQ-015 SHALL have port overflow / underflow  output  1 each  sticky error flags (see Configuration).
REQ-016 SHALL have port clr_err  input  1  clears error flags and max_level.

Function
REQ-017 pop_ok = pop & ~empty; push_ok = push & (~full | pop_ok).
REQ-018 Full with push & pop: both accepted, level unchanged, no overflow.
REQ-019 Empty with push & pop: push accepted, pop rejected (no bypass), underflow event.
REQ-020 push_ok writes din at wr_ptr; wr_ptr advances; wraps DEPTH-1 -> 0.
REQ-021 pop_ok advances rd_ptr; wraps DEPTH-1 -> 0.
REQ-022 dout = mem[rd_ptr] combinationally; valid whenever empty=0; value unspecified when empty.
REQ-023 Write-to-read latency: data pushed in cycle N visible on dout with empty=0 in cycle N+1.
REQ-024 level next = level + push_ok - pop_ok; never exceeds DEPTH, never below 0.
REQ-025 full, empty, afull, aempty SHALL be registered, derived from next level; no combinational path from push/pop.
REQ-026 max_level updates to next level when next level > max_level.
REQ-027 clr_err same cycle as a level increase: max_level loads next level (clear wins, then sample).
REQ-028 Data order SHALL be strict FIFO across any number of pointer wraps.

Reset
REQ-029 rst=1 at a clock edge: level=0, max_level=0, pointers=0, empty=1, aempty=1, full=0, afull=0 (unless AFULL_LVL=0), overflow=0, underflow=0.
REQ-030 rst SHALL override push, pop and clr_err in the same cycle; in-flight data discarded; mem contents not reset.

Configuration
REQ-031 Macro PARAM_FIFO_ERR_EN defined: overflow sets on push & ~push_ok, underflow sets on pop & empty; both hold until rst or clr_err; a set event in the clr_err cycle wins.
REQ-032 Macro PARAM_FIFO_ERR_EN undefined: overflow and underflow tied 0, no error logic; rejected requests still dropped silently.

Verification (WIDTH=8, DEPTH=4, defaults, PARAM_FIFO_ERR_EN defined)
REQ-033 Push 0x01..0x04 on 4 cycles, no pop -> full=1, afull=1 after 4th edge, level=4, dout=0x01, max_level=4.
REQ-034 From full, push 0x05 alone -> overflow=1, level=4; then pop x4 -> dout 0x01,0x02,0x03,0x04, empty=1.
REQ-035 From full, push 0x05 with pop -> level=4, overflow=0, subsequent pops yield 0x02..0x05.
REQ-036 Empty, push 0xAA with pop -> underflow=1, level=1, dout=0xAA next cycle; clr_err -> underflow=0, max_level=1.
REQ-037 Continuous push+pop of 0..255 for 300 cycles after preload of 2 -> level stays 2, data in order across wraps, no error flags.
REQ-038 rst asserted mid-stream at level=3 -> next cycle level=0, empty=1, max_level=0, flags 0; following push 0x10 appears on dout.

Source files
------------

// File: rtl/param_fifo.sv
// param_fifo: parameterised synchronous show-ahead FIFO with registered
// occupancy flags, a high-water mark and optional sticky error flags.
//
// Optional feature macro: PARAM_FIFO_ERR_EN
//   defined   -> overflow/underflow are sticky error flags, cleared by rst/clr_err
//   undefined -> overflow/underflow tied low; rejected requests are dropped silently
//
// Reset is synchronous and active-high; memory contents are never reset.

module param_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int AFULL_LVL  = DEPTH - 1,
    parameter int AEMPTY_LVL = 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [CW-1:0]    level,
    output logic [CW-1:0]    max_level,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;
    logic [CW-1:0]    level_nxt;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request qualification; a pop frees a slot so a push into a full FIFO
    // is accepted in the same cycle. No bypass when empty.
    always_comb begin
        pop_ok    = pop & ~empty;
        push_ok   = push & (~full | pop_ok);
        level_nxt = level + CW'(push_ok) - CW'(pop_ok);
    end

    // Storage write; not reset, stale contents are unreachable after reset.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    // Show-ahead read: head of queue is always presented.
    assign dout = mem[rd_ptr];

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            level <= level_nxt;
        end
    end

    // Status flags registered from the next level, so they carry no
    // combinational path from push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'(AFULL_LVL == 0);
            aempty <= 1'(AEMPTY_LVL >= 0);
        end else begin
            full   <= (level_nxt == CW'(DEPTH));
            empty  <= (level_nxt == '0);
            afull  <= (int'(level_nxt) >= AFULL_LVL);
            aempty <= (int'(level_nxt) <= AEMPTY_LVL);
        end
    end

    // High-water mark; clr_err clears then samples the next level.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_level <= '0;
        end else if (clr_err) begin
            max_level <= level_nxt;
        end else if (level_nxt > max_level) begin
            max_level <= level_nxt;
        end
    end

`ifdef PARAM_FIFO_ERR_EN
    logic ovf_set;
    logic unf_set;

    always_comb begin
        ovf_set = push & ~push_ok;
        unf_set = pop & empty;
    end

    // Sticky error flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (unf_set)      underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (WIDTH=8, DEPTH=4, default levels).
// A queue scoreboard holds the expected contents; error-flag expectations
// follow whether PARAM_FIFO_ERR_EN is defined for the build.

module tb_param_fifo;

`ifdef PARAM_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [7:0] din = '0;
    logic       pop = 1'b0;
    logic [7:0] dout;
    logic       full, empty, afull, aempty;
    logic [2:0] level, max_level;
    logic       overflow, underflow;
    logic       clr_err = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    int         mmax = 0;
    bit         movf = 0;
    bit         munf = 0;

    param_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop), .dout(dout),
        .full(full), .empty(empty), .afull(afull), .aempty(aempty),
        .level(level), .max_level(max_level),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the scoreboard model advances with it.
    task automatic step(input bit p, input logic [7:0] d, input bit o,
                        input bit c, input bit r);
        int         sz;
        bit         pok, wok;
        logic [7:0] tmp;
        push = p; din = d; pop = o; clr_err = c; rst = r;
        sz  = q.size();
        pok = o && (sz > 0);
        wok = p && ((sz < 4) || pok);
        if (r) begin
            q.delete(); mmax = 0; movf = 0; munf = 0;
        end else begin
            if (pok) tmp = q.pop_front();
            if (wok) q.push_back(d);
            if (c) mmax = q.size();
            else if (q.size() > mmax) mmax = q.size();
            if (ERR_EN) begin
                if (p && !wok) movf = 1; else if (c) movf = 0;
                if (o && sz == 0) munf = 1; else if (c) munf = 0;
            end
        end
        @(posedge clk); #1;
        push = 0; pop = 0; clr_err = 0; rst = 0;
    endtask

    task automatic test_reset();
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h55, 1, 1, 1);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (max_level !== 3'd0) begin errors++; $display("FAIL reset_max got=%0d exp=0", max_level); end
        checks++; if ({full, empty, afull, aempty} !== 4'b0101) begin errors++; $display("FAIL reset_flags got=%b exp=0101", {full, empty, afull, aempty}); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            step(1, 8'(i), 0, 0, 0);
            checks++; if (level !== 3'(q.size())) begin errors++; $display("FAIL fill_level got=%0d exp=%0d", level, q.size()); end
            checks++; if (aempty !== (q.size() <= 1)) begin errors++; $display("FAIL fill_aempty got=%b exp=%b", aempty, q.size() <= 1); end
            checks++; if (afull !== (q.size() >= 3)) begin errors++; $display("FAIL fill_afull got=%b exp=%b", afull, q.size() >= 3); end
            checks++; if (full !== (q.size() == 4)) begin errors++; $display("FAIL fill_full got=%b exp=%b", full, q.size() == 4); end
        end
        checks++; if (dout !== q[0]) begin errors++; $display("FAIL fill_dout got=%h exp=%h", dout, q[0]); end
        checks++; if (max_level !== 3'(mmax)) begin errors++; $display("FAIL fill_max got=%0d exp=%0d", max_level, mmax); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b exp=0", empty); end
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            checks++; if (dout !== q[0]) begin errors++; $display("FAIL %s_dout got=%h exp=%h", tag, dout, q[0]); end
            step(0, 8'h00, 1, 0, 0);
        end
        checks++; if (empty !== 1'b1 || level !== 3'd0) begin errors++; $display("FAIL %s_empty got=%b/%0d exp=1/0", tag, empty, level); end
    endtask

    task automatic test_overflow();
        step(1, 8'h05, 0, 0, 0);
        checks++; if (overflow !== movf) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", overflow, movf); end
        checks++; if (level !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL ovf_level got=%0d/%b exp=4/1", level, full); end
        drain("ovf_drain");
        checks++; if (overflow !== movf) begin errors++; $display("FAIL ovf_sticky got=%b exp=%b", overflow, movf); end
        step(0, 8'h00, 0, 1, 0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        step(0, 8'h00, 0, 0, 1);
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0, 0);
        checks++; if (dout !== 8'h01) begin errors++; $display("FAIL fpp_head got=%h exp=01", dout); end
        step(1, 8'h05, 1, 0, 0);
        checks++; if (level !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL fpp_level got=%0d/%b exp=4/1", level, full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
        drain("fpp_drain");
    endtask

    task automatic test_underflow();
        step(1, 8'hAA, 1, 0, 0);
        checks++; if (underflow !== munf) begin errors++; $display("FAIL unf_flag got=%b exp=%b", underflow, munf); end
        checks++; if (level !== 3'd1 || empty !== 1'b0) begin errors++; $display("FAIL unf_level got=%0d/%b exp=1/0", level, empty); end
        checks++; if (dout !== 8'hAA) begin errors++; $display("FAIL unf_dout got=%h exp=aa", dout); end
        step(0, 8'h00, 0, 1, 0);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got=%b exp=0", underflow); end
        checks++; if (max_level !== 3'(mmax)) begin errors++; $display("FAIL unf_max got=%0d exp=%0d", max_level, mmax); end
        drain("unf_drain");
    endtask

    task automatic test_stream();
        int v = 0;
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'(v), 0, 0, 0); v++;
        step(1, 8'(v), 0, 0, 0); v++;
        for (int i = 0; i < 300; i++) begin
            checks++; if (dout !== q[0]) begin errors++; $display("FAIL stream_dout cyc=%0d got=%h exp=%h", i, dout, q[0]); end
            step(1, 8'(v), 1, 0, 0); v++;
            checks++; if (level !== 3'd2) begin errors++; $display("FAIL stream_level cyc=%0d got=%0d exp=2", i, level); end
        end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL stream_err got=%b exp=00", {overflow, underflow}); end
        checks++; if (max_level !== 3'd2) begin errors++; $display("FAIL stream_max got=%0d exp=2", max_level); end
        drain("stream_drain");
    endtask

    task automatic test_mid_reset();
        step(0, 8'h00, 1, 0, 0);
        checks++; if (underflow !== munf) begin errors++; $display("FAIL mrst_unf got=%b exp=%b", underflow, munf); end
        for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL mrst_pre got=%0d exp=3", level); end
        step(1, 8'h77, 1, 1, 1);
        checks++; if (level !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL mrst_level got=%0d/%b exp=0/1", level, empty); end
        checks++; if (max_level !== 3'd0) begin errors++; $display("FAIL mrst_max got=%0d exp=0", max_level); end
        checks++; if ({full, afull, overflow, underflow} !== 4'b0000) begin errors++; $display("FAIL mrst_flags got=%b exp=0000", {full, afull, overflow, underflow}); end
        step(1, 8'h10, 0, 0, 0);
        checks++; if (dout !== 8'h10 || empty !== 1'b0 || level !== 3'd1) begin errors++; $display("FAIL mrst_push got=%h/%b/%0d exp=10/0/1", dout, empty, level); end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_underflow();
        test_stream();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
